// File: rtl/snoopy_invalidate_responder.sv
// Snoop-side responder of an invalidate-protocol snoopy cache: tag lookup, dirty-line intervention, state update.
// Optional hit/intervention counters are built when SNOOP_STATISTICS_EN is defined.
module snoopy_invalidate_responder #(
  parameter int TAG_WIDTH    = 8,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int STATE_WIDTH  = 2
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        commandValid,
  input  logic [1:0]                                  commandIn,
  input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] addressIn,
  output logic                                        commandDone,
  output logic                                        hit,
  output logic [INDEX_WIDTH-1:0]                      cacheIndex,
  output logic [OFFSET_WIDTH-1:0]                     cacheOffset,
  input  logic [TAG_WIDTH-1:0]                        cacheTag,
  input  logic [STATE_WIDTH-1:0]                      cacheState,
  input  logic [DATA_WIDTH-1:0]                       cacheData,
  output logic                                        stateWrite,
  output logic [STATE_WIDTH-1:0]                      stateNext,
  output logic [DATA_WIDTH-1:0]                       dataOut,
  output logic                                        dataValid,
  input  logic                                        dataReady
`ifdef SNOOP_STATISTICS_EN
  ,
  output logic [15:0]                                 snoopHitCount,
  output logic [15:0]                                 interventionCount
`endif
);

  localparam int ADDR_W = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_READ = 2'd1;
  localparam logic [1:0] CMD_INV  = 2'd3;
  localparam logic [STATE_WIDTH-1:0] ST_INVALID = STATE_WIDTH'(0);
  localparam logic [STATE_WIDTH-1:0] ST_VALID   = STATE_WIDTH'(1);
  localparam logic [STATE_WIDTH-1:0] ST_DIRTY   = STATE_WIDTH'(2);

  typedef enum logic [2:0] {IDLE, LOOKUP, SUPPLY, UPDATE, DONE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [INDEX_WIDTH-1:0]  index_q, index_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic                    done_q, done_d, hit_q, hit_d, wr_q, wr_d, dv_q, dv_d;
  logic [STATE_WIDTH-1:0]  next_q, next_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    lookup_hit, xfer;
  logic [STATE_WIDTH-1:0]  update_state;
  logic                    unused_offset;

  assign unused_offset = ^addressIn[OFFSET_WIDTH-1:0];
  assign lookup_hit    = (cacheState != ST_INVALID) && (cacheTag == tag_q);
  assign xfer          = dv_q && dataReady;
  // Reads leave a clean shared copy; exclusive reads and invalidates drop the line.
  assign update_state  = (cmd_q == CMD_READ) ? ST_VALID : ST_INVALID;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    tag_d   = tag_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hit_d   = hit_q;
    wr_d    = 1'b0;
    next_d  = '0;
    dv_d    = dv_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (commandValid) begin
          cmd_d   = commandIn;
          tag_d   = addressIn[ADDR_W-1 -: TAG_WIDTH];
          index_d = addressIn[OFFSET_WIDTH +: INDEX_WIDTH];
          cnt_d   = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = lookup_hit;
        if (!lookup_hit || cmd_q == CMD_NONE ||
            (cacheState == ST_VALID && cmd_q == CMD_READ)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (cacheState == ST_DIRTY && cmd_q != CMD_INV) begin
          state_d = SUPPLY;
          dv_d    = 1'b1;
          dout_d  = cacheData;
        end else begin
          state_d = UPDATE;
          wr_d    = 1'b1;
          next_d  = update_state;
        end
      end
      SUPPLY: begin
        if (xfer) begin
          cnt_d = cnt_q + OFFSET_WIDTH'(1);
          if (cnt_q == '1) begin
            dv_d    = 1'b0;
            dout_d  = '0;
            state_d = UPDATE;
            wr_d    = 1'b1;
            next_d  = update_state;
          end else begin
            dout_d = cacheData;
          end
        end
      end
      UPDATE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        hit_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cacheIndex  = index_q;
    cacheOffset = '0;
    if (state_q == IDLE)
      cacheIndex = commandValid ? addressIn[OFFSET_WIDTH +: INDEX_WIDTH] : '0;
    // The array has one cycle of read latency, so address the word after the one loading into dataOut.
    if (state_q == LOOKUP || state_q == SUPPLY)
      cacheOffset = cnt_d + OFFSET_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NONE;
      tag_q   <= '0;
      index_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      wr_q    <= 1'b0;
      next_q  <= '0;
      dv_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      wr_q    <= wr_d;
      next_q  <= next_d;
      dv_q    <= dv_d;
      dout_q  <= dout_d;
    end
  end

  assign commandDone = done_q;
  assign hit         = hit_q;
  assign stateWrite  = wr_q;
  assign stateNext   = next_q;
  assign dataOut     = dout_q;
  assign dataValid   = dv_q;

`ifdef SNOOP_STATISTICS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, iv_cnt_q, iv_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    iv_cnt_d  = iv_cnt_q;
    if (state_q == DONE && hit_q && hit_cnt_q != 16'hFFFF)
      hit_cnt_d = hit_cnt_q + 16'd1;
    if (state_q == LOOKUP && state_d == SUPPLY && iv_cnt_q != 16'hFFFF)
      iv_cnt_d = iv_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_q <= '0;
      iv_cnt_q  <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      iv_cnt_q  <= iv_cnt_d;
    end
  end

  assign snoopHitCount     = hit_cnt_q;
  assign interventionCount = iv_cnt_q;
`endif

endmodule

// File: tb/tb_snoopy_invalidate_responder.sv
// Bench for snoopy_invalidate_responder: directed scenarios plus random snoops against a table-driven protocol model.
module tb_snoopy_invalidate_responder;
  localparam int TW = 8, IW = 6, OW = 4, DW = 32, SW = 2, NW = 16;
  localparam int AW = TW + IW + OW;

  logic          clock = 1'b0, reset = 1'b0, commandValid = 1'b0, dataReady = 1'b1;
  logic [1:0]    commandIn = 2'd0;
  logic [AW-1:0] addressIn = '0;
  logic          commandDone, hit, stateWrite, dataValid;
  logic [IW-1:0] cacheIndex;
  logic [OW-1:0] cacheOffset;
  logic [TW-1:0] cacheTag;
  logic [SW-1:0] cacheState, stateNext;
  logic [DW-1:0] cacheData, dataOut;
`ifdef SNOOP_STATISTICS_EN
  logic [15:0]   snoopHitCount, interventionCount;
`endif

  snoopy_invalidate_responder dut (
    .clock(clock), .reset(reset), .commandValid(commandValid), .commandIn(commandIn),
    .addressIn(addressIn), .commandDone(commandDone), .hit(hit), .cacheIndex(cacheIndex),
    .cacheOffset(cacheOffset), .cacheTag(cacheTag), .cacheState(cacheState), .cacheData(cacheData),
    .stateWrite(stateWrite), .stateNext(stateNext), .dataOut(dataOut), .dataValid(dataValid),
    .dataReady(dataReady)
`ifdef SNOOP_STATISTICS_EN
    , .snoopHitCount(snoopHitCount), .interventionCount(interventionCount)
`endif
  );

  always #5 clock = ~clock;

  // Tag/state/data array with one cycle of read latency.
  logic [TW-1:0] tag_m [64];
  logic [SW-1:0] st_m [64];
  logic [DW-1:0] data_m [64][16];
  logic [SW-1:0] ref_st [64];

  always @(posedge clock) begin
    cacheTag   <= tag_m[cacheIndex];
    cacheState <= st_m[cacheIndex];
    cacheData  <= data_m[cacheIndex][cacheOffset];
    if (stateWrite) st_m[cacheIndex] = stateNext;
  end

  int errors = 0, checks = 0;
  int done_cyc, wr_cnt, wr_cyc, hold_bad, stalls;
  logic obs_hit;
  logic [SW-1:0] wr_val;
  logic [DW-1:0] stall_val;
  logic [DW-1:0] words[$];

  function automatic logic [AW-1:0] mk_addr(input logic [TW-1:0] t, input int idx, input int off);
    return {t, IW'(idx), OW'(off)};
  endfunction

  task automatic set_line(input int idx, input logic [TW-1:0] t, input logic [SW-1:0] s, input logic [DW-1:0] base);
    tag_m[idx] = t; st_m[idx] = s; ref_st[idx] = s;
    for (int w = 0; w < NW; w++) data_m[idx][w] = base + DW'(w);
  endtask

  // Protocol table: hit, intervention, write and latency for one snoop.
  task automatic model(input logic [1:0] cmd, input logic [TW-1:0] t, input int idx,
                       output bit e_hit, output bit e_sup, output bit e_wr,
                       output logic [SW-1:0] e_nx, output int e_lat);
    logic [SW-1:0] s;
    s = ref_st[idx];
    e_hit = (s != 2'd0) && (tag_m[idx] == t);
    e_sup = 0; e_wr = 0; e_nx = 2'd0; e_lat = 2;
    if (e_hit && cmd != 2'd0) begin
      if (s == 2'd2 && cmd != 2'd3) begin
        e_sup = 1; e_wr = 1; e_nx = (cmd == 2'd1) ? 2'd1 : 2'd0; e_lat = 3 + NW;
      end else if (!(s == 2'd1 && cmd == 2'd1)) begin
        e_wr = 1; e_nx = (cmd == 2'd1) ? 2'd1 : 2'd0; e_lat = 3;
      end
    end
  endtask

  // Drives one snoop and records what the DUT did; the calling test judges it.
  task automatic do_txn(input logic [1:0] cmd, input logic [AW-1:0] addr, input int stall_word,
                        input int stall_len, input bit rnd_ready, input bit chain);
    int cyc, left;
    bit prev_stall;
    logic [DW-1:0] prev_out;
    cyc = 0; left = stall_len; prev_stall = 0; prev_out = '0;
    words.delete(); done_cyc = -1; wr_cnt = 0; wr_cyc = -1; wr_val = '0;
    hold_bad = 0; stalls = 0; stall_val = '0; obs_hit = 0;
    commandValid = 1'b1; commandIn = cmd; addressIn = addr; dataReady = 1'b1;
    while (done_cyc < 0 && cyc <= 200) begin
      @(negedge clock); cyc++;
      if (stateWrite) begin wr_cnt++; wr_cyc = cyc; wr_val = stateNext; end
      if (dataValid) begin
        if (prev_stall && dataOut !== prev_out) hold_bad++;
        if (left > 0 && words.size() == stall_word) begin dataReady = 1'b0; left--; end
        else if (rnd_ready) dataReady = ($urandom_range(0, 3) != 0);
        else dataReady = 1'b1;
        if (dataReady) words.push_back(dataOut);
        else begin stalls++; stall_val = dataOut; end
        prev_stall = !dataReady; prev_out = dataOut;
      end else begin
        dataReady = 1'b1; prev_stall = 0;
      end
      if (commandDone) begin done_cyc = cyc; obs_hit = hit; end
    end
    if (!chain) begin commandValid = 1'b0; @(negedge clock); end
  endtask

  function automatic int words_bad(input int idx);
    int bad;
    bad = (words.size() != NW) ? 1 : 0;
    if (bad == 0) for (int i = 0; i < NW; i++) if (words[i] !== data_m[idx][i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({commandDone, hit, stateWrite, stateNext, dataOut, dataValid, cacheIndex, cacheOffset} !== '0) begin
      errors++; $display("FAIL reset_held outputs=%h required 0", {commandDone, hit, stateWrite, stateNext, dataOut, dataValid});
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({commandDone, hit, stateWrite, dataValid, cacheIndex, cacheOffset} !== '0) begin
      errors++; $display("FAIL idle_after_reset outputs nonzero done=%b hit=%b wr=%b dv=%b", commandDone, hit, stateWrite, dataValid);
    end
  endtask

  task automatic test_read_valid_hit();
    set_line(5, 8'h3A, 2'd1, 32'h0);
    do_txn(2'd1, mk_addr(8'h3A, 5, 3), -1, 0, 0, 0);
    checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL read_hit hit=%b required 1", obs_hit); end
    checks++; if (wr_cnt != 0) begin errors++; $display("FAIL read_hit writes=%0d required 0", wr_cnt); end
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL read_hit latency=%0d required 2", done_cyc); end
    checks++; if (words.size() != 0) begin errors++; $display("FAIL read_hit words=%0d required 0", words.size()); end
  endtask

  task automatic test_rdx_miss();
    set_line(5, 8'h3B, 2'd2, 32'h0);
    do_txn(2'd2, mk_addr(8'h3A, 5, 0), -1, 0, 0, 0);
    checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL rdx_miss hit=%b required 0", obs_hit); end
    checks++; if (wr_cnt != 0 || words.size() != 0) begin
      errors++; $display("FAIL rdx_miss writes=%0d words=%0d required 0/0", wr_cnt, words.size()); end
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL rdx_miss latency=%0d required 2", done_cyc); end
  endtask

  task automatic test_supply();
    set_line(9, 8'h44, 2'd2, 32'h100);
    do_txn(2'd1, mk_addr(8'h44, 9, 7), -1, 0, 0, 0);
    checks++; if (words_bad(9) != 0) begin errors++; $display("FAIL supply_words got %0d words, required 16 from 0x100", words.size()); end
    checks++; if (wr_cnt != 1 || wr_val !== 2'd1 || wr_cyc != 18) begin
      errors++; $display("FAIL supply_write cnt=%0d val=%0d cyc=%0d required 1/1/18", wr_cnt, wr_val, wr_cyc); end
    checks++; if (done_cyc != 19 || obs_hit !== 1'b1) begin
      errors++; $display("FAIL supply_done latency=%0d hit=%b required 19/1", done_cyc, obs_hit); end
    checks++; if (st_m[9] !== 2'd1) begin errors++; $display("FAIL supply_state line=%0d required 1", st_m[9]); end
    ref_st[9] = 2'd1;
  endtask

  task automatic test_supply_stall();
    set_line(9, 8'h44, 2'd2, 32'h100);
    do_txn(2'd1, mk_addr(8'h44, 9, 0), 7, 3, 0, 0);
    checks++; if (words_bad(9) != 0) begin errors++; $display("FAIL stall_words got %0d words, required 16 from 0x100", words.size()); end
    checks++; if (hold_bad != 0 || stalls != 3 || stall_val !== 32'h107) begin
      errors++; $display("FAIL stall_hold unstable=%0d stalls=%0d held=%h required 0/3/107", hold_bad, stalls, stall_val); end
    checks++; if (done_cyc != 22 || wr_val !== 2'd1) begin
      errors++; $display("FAIL stall_done latency=%0d next=%0d required 22/1", done_cyc, wr_val); end
    ref_st[9] = 2'd1;
  endtask

  task automatic test_invalidate_valid();
    set_line(20, 8'h77, 2'd1, 32'h0);
    do_txn(2'd3, mk_addr(8'h77, 20, 9), -1, 0, 0, 0);
    checks++; if (wr_cnt != 1 || wr_val !== 2'd0 || wr_cyc != 2) begin
      errors++; $display("FAIL inval_write cnt=%0d val=%0d cyc=%0d required 1/0/2", wr_cnt, wr_val, wr_cyc); end
    checks++; if (done_cyc != 3 || obs_hit !== 1'b1) begin
      errors++; $display("FAIL inval_done latency=%0d hit=%b required 3/1", done_cyc, obs_hit); end
    ref_st[20] = 2'd0;
  endtask

  task automatic test_reset_mid_supply();
    bit found;
    int wseen;
    set_line(12, 8'h55, 2'd2, 32'hA00);
    found = 0;
    commandValid = 1'b1; commandIn = 2'd1; addressIn = mk_addr(8'h55, 12, 5); dataReady = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (dataValid && dataOut === data_m[12][4]) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_reach word4 seen=0 required 1"); end
    reset = 1'b0; commandValid = 1'b0;
    #1;
    checks++;
    if ({commandDone, hit, stateWrite, stateNext, dataOut, dataValid, cacheIndex, cacheOffset} !== '0) begin
      errors++; $display("FAIL midreset_outputs dv=%b dout=%h wr=%b required all 0", dataValid, dataOut, stateWrite);
    end
    wseen = 0;
    repeat (3) begin @(negedge clock); if (stateWrite) wseen++; end
    reset = 1'b1;
    @(negedge clock); if (stateWrite) wseen++;
    checks++; if (wseen != 0 || st_m[12] !== 2'd2) begin
      errors++; $display("FAIL midreset_nowrite writes=%0d line=%0d required 0/2", wseen, st_m[12]); end
    do_txn(2'd1, mk_addr(8'h55, 12, 5), -1, 0, 0, 0);
    checks++; if (words_bad(12) != 0 || done_cyc != 19) begin
      errors++; $display("FAIL midreset_resupply words=%0d latency=%0d required 16/19", words.size(), done_cyc); end
    ref_st[12] = 2'd1;
  endtask

  task automatic test_back_to_back();
    set_line(30, 8'h10, 2'd1, 32'h0);
    set_line(31, 8'h20, 2'd0, 32'h0);
    do_txn(2'd1, mk_addr(8'h10, 30, 0), -1, 0, 0, 1);
    checks++; if (done_cyc != 2 || obs_hit !== 1'b1) begin
      errors++; $display("FAIL b2b_first latency=%0d hit=%b required 2/1", done_cyc, obs_hit); end
    do_txn(2'd2, mk_addr(8'h20, 31, 0), -1, 0, 0, 0);
    checks++; if (done_cyc != 3 || obs_hit !== 1'b0) begin
      errors++; $display("FAIL b2b_second latency=%0d hit=%b required 3/0", done_cyc, obs_hit); end
  endtask

  task automatic test_random();
    bit e_hit, e_sup, e_wr;
    logic [SW-1:0] e_nx;
    int e_lat, idx;
    logic [1:0] cmd;
    logic [TW-1:0] t;
    for (int n = 0; n < 40; n++) begin
      idx = 40 + $urandom_range(0, 7);
      cmd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin st_m[idx] = 2'($urandom_range(0, 2)); ref_st[idx] = st_m[idx]; end
      t = ($urandom_range(0, 1) != 0) ? tag_m[idx] : (tag_m[idx] ^ 8'h01);
      model(cmd, t, idx, e_hit, e_sup, e_wr, e_nx, e_lat);
      do_txn(cmd, mk_addr(t, idx, $urandom_range(0, 15)), -1, 0, 1, 0);
      checks++; if (obs_hit !== e_hit) begin errors++; $display("FAIL rnd%0d_hit hit=%b required %b", n, obs_hit, e_hit); end
      checks++; if (done_cyc != e_lat + stalls) begin
        errors++; $display("FAIL rnd%0d_latency latency=%0d required %0d", n, done_cyc, e_lat + stalls); end
      checks++; if (wr_cnt != int'(e_wr) || (e_wr && wr_val !== e_nx)) begin
        errors++; $display("FAIL rnd%0d_write cnt=%0d val=%0d required %0d/%0d", n, wr_cnt, wr_val, e_wr, e_nx); end
      checks++; if ((e_sup && (words_bad(idx) != 0 || hold_bad != 0)) || (!e_sup && words.size() != 0)) begin
        errors++; $display("FAIL rnd%0d_data words=%0d unstable=%0d required %0d/0", n, words.size(), hold_bad, e_sup ? NW : 0); end
      if (e_wr) ref_st[idx] = e_nx;
      checks++; if (st_m[idx] !== ref_st[idx]) begin
        errors++; $display("FAIL rnd%0d_state line=%0d required %0d", n, st_m[idx], ref_st[idx]); end
    end
  endtask

  initial begin
    for (int s = 0; s < 64; s++) begin
      tag_m[s] = 8'($urandom); st_m[s] = 2'd0; ref_st[s] = 2'd0;
      for (int w = 0; w < NW; w++) data_m[s][w] = $urandom;
    end
    test_reset();
    test_read_valid_hit();
    test_rdx_miss();
    test_supply();
    test_supply_stall();
    test_invalidate_valid();
    test_reset_mid_supply();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snoopy_invalidate_responder.md
Name: snoopy_invalidate_responder

Overview:
- Snoop-side responder of the invalidate-protocol snoopy cache.
- Accepts one foreign bus transaction at a time, looks up the local tag/state array, and applies the snoopy state transition.
- Supplies the line when the local copy is DIRTY and the command needs data; invalidates on exclusive/invalidate commands.
- Sits between the shared bus snoop port and the cache tag/state/data array, opposite the CPU-side protocol controller.

Parameters:
- TAG_WIDTH, 8, tag bits of the snooped address.
- INDEX_WIDTH, 6, set index bits.
- OFFSET_WIDTH, 4, word-offset bits; a line holds 2^OFFSET_WIDTH words.
- DATA_WIDTH, 32, bus data word width.
- STATE_WIDTH, 2, width of the state encoding (INVALID=0, VALID=1, DIRTY=2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- commandValid  in  1  snoop transaction present; held high until commandDone.
- commandIn  in  2  NONE=0, BUS_READ=1, BUS_READ_EXCLUSIVE=2, BUS_INVALIDATE=3.
- addressIn  in  TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH  snooped address.
- commandDone  out  1  one-cycle pulse when the transaction is finished.
- hit  out  1  registered; valid in the commandDone cycle.
- cacheIndex  out  INDEX_WIDTH  set index driven to the array.
- cacheOffset  out  OFFSET_WIDTH  word offset driven to the array.
- cacheTag  in  TAG_WIDTH  stored tag, valid one cycle after cacheIndex.
- cacheState  in  STATE_WIDTH  stored state, valid one cycle after cacheIndex.
- cacheData  in  DATA_WIDTH  word at cacheIndex/cacheOffset, same one-cycle latency.
- stateWrite  out  1  write-enable of stateNext into the set.
- stateNext  out  STATE_WIDTH  new state.
- dataOut  out  DATA_WIDTH  intervention data word.
- dataValid  out  1  dataOut valid.
- dataReady  in  1  bus accepts the word; transfer when dataValid && dataReady.

Behaviour:
- Reset (async, low): state IDLE; all outputs 0; address latch and word counter cleared. A reset mid-supply abandons the line and no state write occurs.
- FSM states: IDLE, LOOKUP, SUPPLY, UPDATE, DONE.
- IDLE:
  - On commandValid, latch commandIn and addressIn, drive cacheIndex, set cacheOffset=0, go to LOOKUP.
  - commandValid is ignored in every other state.
- LOOKUP:
  - hit = (cacheState != INVALID) && (cacheTag == latched tag).
  - Miss, or command NONE: go to DONE with no state write.
  - Hit with DIRTY and command BUS_READ or BUS_READ_EXCLUSIVE: go to SUPPLY.
  - Hit with VALID and command BUS_READ: go to DONE; the state stays VALID.
  - Any other hit: go to UPDATE.
- SUPPLY:
  - Stream words 0 .. 2^OFFSET_WIDTH-1 in order, starting at offset 0 regardless of the snooped offset.
  - dataOut/dataValid are registered. The counter advances only on a transfer. dataOut holds stable while dataValid && !dataReady.
  - cacheOffset runs one word ahead of the counter, so there are no bubbles when dataReady stays high.
  - After the last transfer, dataValid drops and the FSM goes to UPDATE; the counter wraps to 0.
- UPDATE: stateWrite=1 for exactly one cycle.
  - BUS_READ: DIRTY->VALID.
  - BUS_READ_EXCLUSIVE or BUS_INVALIDATE: any state->INVALID.
  - BUS_INVALIDATE on DIRTY invalidates without supplying data.
- DONE: commandDone=1 for one cycle, hit held, then IDLE. A new commandValid is accepted no earlier than the cycle after DONE.
- Latency from accept edge to commandDone:
  - miss or no-write hit: 2 cycles;
  - hit with update: 3 cycles;
  - supply: 3 + 2^OFFSET_WIDTH cycles minimum, plus stall cycles.

Optional Feature:
- Macro SNOOP_STATISTICS_EN.
- Defined: adds outputs snoopHitCount and interventionCount, each 16 bits.
  - They increment in the DONE cycle of a hit, and on entry to SUPPLY, respectively.
  - They saturate at 0xFFFF and reset to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- BUS_READ, set 5 holds tag 0x3A VALID, address tag 0x3A -> hit=1, no stateWrite, commandDone 2 cycles after accept.
- BUS_READ_EXCLUSIVE, tag 0x3A mismatched (stored 0x3B DIRTY) -> hit=0, no dataValid, no stateWrite, commandDone at 2 cycles.
- BUS_READ on DIRTY line with words 0x100..0x10F, dataReady always 1 -> 16 consecutive dataValid words 0x100..0x10F, then stateWrite with stateNext=VALID, commandDone at 19 cycles.
- Same as previous, dataReady low for 3 cycles at word 7 -> dataOut holds 0x107 across the stall, all 16 words delivered once, commandDone at 22 cycles.
- BUS_INVALIDATE on VALID hit -> stateWrite=1 with stateNext=INVALID in cycle 2, commandDone in cycle 3.
- Reset asserted at word 4 of a supply -> all outputs 0 immediately, no stateWrite; the next BUS_READ to the same line re-supplies from word 0.
